riscv_seq_ctrl: RTL and testbench
=================================

Name: riscv_seq_ctrl

Overview:
Multi-cycle instruction sequencer that owns the program counter and the register-file write strobe consumed by riscv_top (pc, write_en).
- Steps each instruction through FETCH, EXEC and WB, and redirects on taken branches.
- Halts on invalid or misaligned instructions and counts retired instructions.
- Sits above riscv_top. Its inputs come from the core's decoder and branch logic.

Parameters:
RESET_PC, 32'h0000_0000, pc_o value after reset; must be 4-byte aligned
MEM_LAT, 1, cycles spent in FETCH waiting for instruction RAM; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level enable; 1 = keep executing, 0 = stop after current instruction
invalid_i  input  1  decoder invalid flag for the instruction at pc_o, valid in EXEC
stall_i  input  1  hold in EXEC while 1
branch_taken_i  input  1  redirect request, sampled in WB
branch_target_i  input  32  redirect address, sampled in WB
pc_o  output  32  current program counter, drives core pc
write_en_o  output  1  register-file write strobe, drives core write_en
halted_o  output  1  sticky halt indication
err_o  output  2  halt cause: 0 none, 1 invalid instruction, 2 misaligned branch target
retired_o  output  32  count of completed WB cycles
busy_o  output  1  1 in FETCH, EXEC or WB

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; all state registers are cleared immediately on rst_n=0, independent of clk.
- Reset values:
  - pc_o=RESET_PC, state=IDLE, write_en_o=0, halted_o=0, err_o=0, retired_o=0, busy_o=0.
  - Reset asserted mid-instruction aborts it: no write strobe is issued and pc_o is not updated.
- States (3-bit encoding): IDLE=0, FETCH=1, EXEC=2, WB=3, HALT=4.
- All outputs are registers or decoded from the state register only; none is combinational from inputs.
  - write_en_o = (state==WB).
  - busy_o = state in {FETCH, EXEC, WB}.
- IDLE:
  - run=1 -> FETCH, and the latency counter is loaded with MEM_LAT-1.
  - Otherwise stay in IDLE.
- FETCH:
  - Counter nonzero: decrement and stay.
  - Counter zero: -> EXEC.
  - Total FETCH residency is exactly MEM_LAT cycles; pc_o is stable throughout.
- EXEC, one cycle minimum. Priority:
  1. invalid_i=1 -> HALT, err_o=1.
  2. stall_i=1 -> stay in EXEC.
  3. Otherwise -> WB.
  - invalid_i takes precedence over stall_i when both are 1.
- WB: exactly one cycle, write_en_o=1. On the edge leaving WB:
  - branch_taken_i=1 and branch_target_i[1:0]!=0 -> HALT, err_o=2. pc_o is unchanged but retired_o still increments, because the register write has already happened.
  - Otherwise pc_o <= branch_taken_i ? branch_target_i : pc_o+4. Addition is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
  - retired_o <= retired_o+1, wrapping at 2^32.
  - Next state: FETCH if run=1 (counter reloaded), else IDLE.
- HALT:
  - halted_o=1 and write_en_o=0; pc_o, err_o and retired_o are frozen.
  - run is ignored; only rst_n exits HALT.
- run deasserted during FETCH or EXEC does not abort: the instruction completes through WB, then the FSM goes to IDLE.
- Throughput with no stall: one instruction every MEM_LAT+2 cycles.
- branch_taken_i and branch_target_i are ignored outside WB.

Test Plan:
- Reset and straight-line run: MEM_LAT=1, RESET_PC=0, run=1, no branch -> pc_o is 0,4,8,12 on cycles 3,6,9. write_en_o pulses one cycle every 3 cycles. retired_o=3 after 9 cycles.
- Latency and stall: MEM_LAT=3, stall_i=1 for 2 cycles in the first EXEC -> first write_en_o pulse at cycle 3+3=6 after run rises. pc_o=4 afterwards.
- Branch redirect: branch_taken_i=1 with target 0x100 during WB -> next pc_o=0x100, no intermediate pc_o=4. Target 0x102 -> halted_o=1, err_o=2, pc_o unchanged, retired_o incremented.
- Invalid instruction: invalid_i=1 in EXEC at pc 0x8 -> HALT, no write_en_o pulse, pc_o=0x8, err_o=1. Toggling run has no effect. rst_n low clears to RESET_PC.
- Run drop and wrap: RESET_PC=0xFFFF_FFFC, run dropped during FETCH -> WB still occurs, pc_o=0x0, state IDLE, busy_o=0.
- Async reset mid-WB: rst_n falls between edges -> write_en_o=0 immediately, pc_o=RESET_PC, retired_o=0.

Source files
------------

// File: rtl/riscv_seq_ctrl_if.sv
// Control/status bundle between the core's decode/branch logic and the sequencer.
// Valid/ready note: there is no handshake; every signal is a level sampled on the rising clk edge.
interface riscv_seq_ctrl_if;
  logic        run;
  logic        invalid_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic        write_en_o;
  logic        halted_o;
  logic [1:0]  err_o;
  logic [31:0] retired_o;
  logic        busy_o;
  logic [2:0]  state;

  modport master (
    output run, invalid_i, stall_i, branch_taken_i, branch_target_i,
    input  pc_o, write_en_o, halted_o, err_o, retired_o, busy_o, state
  );

  modport slave (
    input  run, invalid_i, stall_i, branch_taken_i, branch_target_i,
    output pc_o, write_en_o, halted_o, err_o, retired_o, busy_o, state
  );
endinterface

// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle FETCH/EXEC/WB sequencer owning the program counter, the
// register-file write strobe, the halt cause and the retired-instruction count.
module riscv_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_LAT  = 1
) (
  input logic             clk,
  input logic             rst_n,
  riscv_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_INVALID   = 2'd1;
  localparam logic [1:0] ERR_MISALIGN  = 2'd2;
  localparam logic [3:0] LAT_LOAD      = 4'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] pc, pc_nxt;
  logic [1:0]  err, err_nxt;
  logic [31:0] retired, retired_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pc      <= RESET_PC;
      err     <= ERR_NONE;
      retired <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pc      <= pc_nxt;
      err     <= err_nxt;
      retired <= retired_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_nxt      = pc;
    err_nxt     = err;
    retired_nxt = retired;
    case (state)
      IDLE: begin
        if (bus.run) begin
          state_nxt = FETCH;
          cnt_nxt   = LAT_LOAD;
        end
      end
      FETCH: begin
        if (cnt != 4'd0) cnt_nxt   = cnt - 4'd1;
        else             state_nxt = EXEC;
      end
      EXEC: begin
        // A bad opcode halts even while the core is asking to stall.
        if (bus.invalid_i) begin
          state_nxt = HALT;
          err_nxt   = ERR_INVALID;
        end else if (!bus.stall_i) begin
          state_nxt = WB;
        end
      end
      WB: begin
        // The register write is committed in this cycle, so it retires even
        // when the redirect target turns out to be misaligned.
        retired_nxt = retired + 32'd1;
        if (bus.branch_taken_i && (bus.branch_target_i[1:0] != 2'b00)) begin
          state_nxt = HALT;
          err_nxt   = ERR_MISALIGN;
        end else begin
          pc_nxt = bus.branch_taken_i ? bus.branch_target_i : pc + 32'd4;
          if (bus.run) begin
            state_nxt = FETCH;
            cnt_nxt   = LAT_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.pc_o       = pc;
  assign bus.write_en_o = (state == WB);
  assign bus.halted_o   = (state == HALT);
  assign bus.err_o      = err;
  assign bus.retired_o  = retired;
  assign bus.busy_o     = (state == FETCH) || (state == EXEC) || (state == WB);
  assign bus.state      = state;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Bench for riscv_seq_ctrl: directed vector table, hand-written corner sequences
// and randomized instructions checked against a transaction-level model.
module tb_riscv_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          LAT    = 2;

  logic clk;
  logic rst_n;
  riscv_seq_ctrl_if intf ();

  riscv_seq_ctrl #(.RESET_PC(RST_PC), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [1:0]  m_err;
  bit          m_halted;
  bit          m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // scoreboard: every write strobe must match the next expected pc
  always @(negedge clk) begin
    if (rst_n && intf.write_en_o) begin
      if (exp_q.size() == 0) chk("unexpected_write", intf.pc_o, 32'hxxxx_xxxx);
      else                   chk("write_pc", intf.pc_o, exp_q.pop_front());
    end
  end

  task automatic model_reset();
    m_pc = RST_PC; m_ret = 0; m_err = 0; m_halted = 0; m_idle = 1;
  endtask

  task automatic chk_halt();
    chk("halt_halted", {31'd0, intf.halted_o}, 32'd1);
    chk("halt_err", {30'd0, intf.err_o}, {30'd0, m_err});
    chk("halt_we", {31'd0, intf.write_en_o}, 32'd0);
    chk("halt_busy", {31'd0, intf.busy_o}, 32'd0);
    chk("halt_pc", intf.pc_o, m_pc);
    chk("halt_ret", intf.retired_o, m_ret);
    chk("halt_state", {29'd0, intf.state}, 32'd4);
  endtask

  // async reset asserted between edges; outputs must clear without a clock
  task automatic do_reset();
    #2 rst_n = 1'b0;
    intf.run = 0; intf.invalid_i = 0; intf.stall_i = 0; intf.branch_taken_i = 0;
    #1;
    chk("rst_we", {31'd0, intf.write_en_o}, 32'd0);
    chk("rst_pc", intf.pc_o, RST_PC);
    chk("rst_ret", intf.retired_o, 32'd0);
    chk("rst_halted", {31'd0, intf.halted_o}, 32'd0);
    chk("rst_err", {30'd0, intf.err_o}, 32'd0);
    chk("rst_busy", {31'd0, intf.busy_o}, 32'd0);
    chk("rst_state", {29'd0, intf.state}, 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic halt_toggle(input int n);
    for (int i = 0; i < n; i++) begin
      intf.run = 1'($urandom_range(0, 1));
      tick();
      chk_halt();
    end
  endtask

  // One instruction: FETCH for LAT cycles, EXEC for 1+stalls cycles, one WB.
  task automatic run_instr(input int stalls, input bit taken, input logic [31:0] tgt,
                           input bit bad_i, input bit keep);
    if (m_idle) begin
      chk("idle_busy", {31'd0, intf.busy_o}, 32'd0);
      chk("idle_pc", intf.pc_o, m_pc);
      intf.run = 1'b1;
      tick();
      m_idle = 0;
    end
    intf.run = keep;
    for (int i = 0; i < LAT; i++) begin
      chk("fetch_state", {29'd0, intf.state}, 32'd1);
      chk("fetch_we", {31'd0, intf.write_en_o}, 32'd0);
      chk("fetch_pc", intf.pc_o, m_pc);
      intf.branch_taken_i  = 1'($urandom_range(0, 1));
      intf.branch_target_i = $urandom();
      intf.stall_i         = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 0; i <= stalls; i++) begin
      chk("exec_state", {29'd0, intf.state}, 32'd2);
      chk("exec_busy", {31'd0, intf.busy_o}, 32'd1);
      chk("exec_pc", intf.pc_o, m_pc);
      if (bad_i) begin
        intf.invalid_i = 1'b1;
        intf.stall_i   = 1'($urandom_range(0, 1));
        tick();
        intf.invalid_i = 1'b0;
        intf.stall_i   = 1'b0;
        m_halted = 1; m_err = 2'd1;
        chk_halt();
        return;
      end
      intf.stall_i = (i < stalls);
      if (i == stalls) exp_q.push_back(m_pc);
      tick();
    end
    intf.stall_i = 1'b0;
    chk("wb_state", {29'd0, intf.state}, 32'd3);
    chk("wb_pc", intf.pc_o, m_pc);
    intf.branch_taken_i  = taken;
    intf.branch_target_i = tgt;
    tick();
    intf.branch_taken_i = 1'b0;
    m_ret = m_ret + 1;
    if (taken && (tgt % 4 != 0)) begin
      m_halted = 1; m_err = 2'd2;
      chk_halt();
    end else begin
      m_pc   = taken ? tgt : m_pc + 4;
      m_idle = !keep;
      chk("post_pc", intf.pc_o, m_pc);
      chk("post_ret", intf.retired_o, m_ret);
      chk("post_busy", {31'd0, intf.busy_o}, {31'd0, keep});
    end
  endtask

  typedef struct {
    int          stalls;
    bit          taken;
    logic [31:0] tgt;
    bit          bad_i;
    bit          keep;
    logic [31:0] e_pc;
    logic [31:0] e_ret;
    logic [1:0]  e_err;
    bit          e_busy;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [31:0] r;
    vt[0] = '{0, 0, 32'h0,   0, 1, 32'hFFFF_FFFC, 1, 0, 1};
    vt[1] = '{2, 0, 32'h0,   0, 1, 32'h0000_0000, 2, 0, 1};
    vt[2] = '{0, 1, 32'h100, 0, 1, 32'h0000_0100, 3, 0, 1};
    vt[3] = '{1, 1, 32'h200, 0, 0, 32'h0000_0200, 4, 0, 0};
    vt[4] = '{0, 0, 32'h0,   0, 1, 32'h0000_0204, 5, 0, 1};
    vt[5] = '{3, 0, 32'h0,   1, 1, 32'h0000_0204, 5, 1, 0};

    rst_n = 1'b0;
    intf.run = 0; intf.invalid_i = 0; intf.stall_i = 0;
    intf.branch_taken_i = 0; intf.branch_target_i = 0;
    model_reset();
    tick();
    chk("reset_pc", intf.pc_o, RST_PC);
    chk("reset_state", {29'd0, intf.state}, 32'd0);
    chk("reset_ret", intf.retired_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_hold_busy", {31'd0, intf.busy_o}, 32'd0);

    // directed vectors: wrap, stall, redirect, run drop, invalid-over-stall
    foreach (vt[k]) begin
      run_instr(vt[k].stalls, vt[k].taken, vt[k].tgt, vt[k].bad_i, vt[k].keep);
      chk($sformatf("vec%0d_pc", k), intf.pc_o, vt[k].e_pc);
      chk($sformatf("vec%0d_ret", k), intf.retired_o, vt[k].e_ret);
      chk($sformatf("vec%0d_err", k), {30'd0, intf.err_o}, {30'd0, vt[k].e_err});
      chk($sformatf("vec%0d_busy", k), {31'd0, intf.busy_o}, {31'd0, vt[k].e_busy});
    end
    halt_toggle(4);
    do_reset();

    // misaligned redirect: halts, pc held, instruction still retires
    run_instr(0, 1, 32'h102, 0, 1);
    chk("mis_err", {30'd0, intf.err_o}, 32'd2);
    chk("mis_pc", intf.pc_o, RST_PC);
    chk("mis_ret", intf.retired_o, 32'd1);
    halt_toggle(3);
    do_reset();

    // async reset landing in the middle of a WB cycle
    run_instr(0, 0, 32'h0, 0, 1);
    for (int i = 0; i < LAT; i++) tick();
    exp_q.push_back(m_pc);
    tick();
    chk("midwb_we", {31'd0, intf.write_en_o}, 32'd1);
    do_reset();

    // randomized instructions against the model
    for (int n = 0; n < 60; n++) begin
      int st;
      bit tk, bd, kp;
      logic [31:0] tg;
      if (m_halted) begin
        halt_toggle(2);
        do_reset();
      end
      st = $urandom_range(0, 3);
      tk = ($urandom_range(0, 3) == 0);
      r  = $urandom();
      tg = {r[31:2], 2'b00};
      if ($urandom_range(0, 9) == 0) tg[0] = 1'b1;
      bd = ($urandom_range(0, 19) == 0);
      kp = ($urandom_range(0, 4) != 0);
      run_instr(st, tk, tg, bd, kp);
    end

    tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
